// File: rtl/bomberman_pkg.sv
// Shared types and default constants for the Bomberman game-state blocks.
package bomberman_pkg;

  typedef enum logic [2:0] {
    IDLE,
    STAGGER,
    PLAY,
    HIT,
    OVER
  } life_state_t;

  localparam int DEF_LIVES         = 3;
  localparam int DEF_START_GAP     = 25_000_000;
  localparam int DEF_INVULN_CYCLES = 50_000_000;

endpackage

// File: rtl/life_timer.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module life_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - WIDTH'(1);
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/bomberman_life_ctrl.sv
// Enemy release sequencer, life counter and post-hit invulnerability window.
// Optional sprite blinking during the window is compiled in with LIFE_CTRL_BLINK_EN.
module bomberman_life_ctrl
  import bomberman_pkg::*;
#(
  parameter int NUM_ENEMIES   = 4,
  parameter int START_GAP     = DEF_START_GAP,
  parameter int LIVES         = DEF_LIVES,
  parameter int INVULN_CYCLES = DEF_INVULN_CYCLES,
  parameter int BLINK_LOG2    = 22
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_btn,
  input  logic [NUM_ENEMIES-1:0] death_signal,
  output logic [NUM_ENEMIES-1:0] enemy_start,
  output logic                   game_over,
  output logic [3:0]             lives,
  output logic                   invuln,
  output logic                   respawn_pulse,
  output logic                   bomberman_visible
);

  localparam int GAP_W = $clog2(START_GAP + 1);
  localparam int INV_W = $clog2(INVULN_CYCLES + 1);

  if (NUM_ENEMIES < 1 || NUM_ENEMIES > 8 || START_GAP < 1 || LIVES < 1 || LIVES > 15 ||
      INVULN_CYCLES < 1 || BLINK_LOG2 < 0) begin : g_param_check
    $error("bomberman_life_ctrl: parameter out of range");
  end

  life_state_t            state_reg, state_next;
  logic [NUM_ENEMIES-1:0] enemy_start_reg, enemy_start_next;
  logic [NUM_ENEMIES-1:0] release_mask;
  logic [3:0]             lives_reg, lives_next;
  logic                   game_over_reg, game_over_next;
  logic                   invuln_reg, invuln_next;
  logic                   respawn_reg, respawn_next;
  logic                   gap_load, gap_dec, gap_zero;
  logic                   inv_load, inv_dec, inv_zero;
  logic                   hit;

  life_timer #(.WIDTH(GAP_W)) u_gap_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (gap_load),
    .load_val (GAP_W'(START_GAP - 1)),
    .dec      (gap_dec),
    .zero     (gap_zero)
  );

  life_timer #(.WIDTH(INV_W)) u_inv_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (inv_load),
    .load_val (INV_W'(INVULN_CYCLES - 1)),
    .dec      (inv_dec),
    .zero     (inv_zero)
  );

  // Enemies are released in index order, so the set bits always form a
  // contiguous run from bit 0 and the next release is a shift-in of a one.
  assign release_mask = (enemy_start_reg << 1) | NUM_ENEMIES'(1);
  assign hit          = |death_signal;

  always_comb begin
    state_next       = state_reg;
    enemy_start_next = enemy_start_reg;
    lives_next       = lives_reg;
    game_over_next   = game_over_reg;
    invuln_next      = invuln_reg;
    respawn_next     = 1'b0;
    gap_load         = 1'b0;
    gap_dec          = 1'b0;
    inv_load         = 1'b0;
    inv_dec          = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (start_btn) begin
          enemy_start_next = release_mask;
          gap_load         = 1'b1;
          if (release_mask[NUM_ENEMIES-1]) begin
            state_next  = PLAY;
            invuln_next = 1'b0;
          end else begin
            state_next = STAGGER;
          end
        end
      end
      STAGGER: begin
        if (gap_zero) begin
          enemy_start_next = release_mask;
          gap_load         = 1'b1;
          if (release_mask[NUM_ENEMIES-1]) begin
            state_next  = PLAY;
            invuln_next = 1'b0;
          end
        end else begin
          gap_dec = 1'b1;
        end
      end
      PLAY: begin
        if (hit) begin
          if (lives_reg > 4'd1) begin
            lives_next   = lives_reg - 4'd1;
            state_next   = HIT;
            invuln_next  = 1'b1;
            respawn_next = 1'b1;
            inv_load     = 1'b1;
          end else begin
            lives_next     = 4'd0;
            state_next     = OVER;
            game_over_next = 1'b1;
            invuln_next    = 1'b0;
          end
        end
      end
      HIT: begin
        if (inv_zero) begin
          state_next  = PLAY;
          invuln_next = 1'b0;
        end else begin
          inv_dec = 1'b1;
        end
      end
      OVER: begin
        game_over_next = 1'b1;
        invuln_next    = 1'b0;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      enemy_start_reg <= '0;
      lives_reg       <= 4'(LIVES);
      game_over_reg   <= 1'b0;
      invuln_reg      <= 1'b1;
      respawn_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      enemy_start_reg <= enemy_start_next;
      lives_reg       <= lives_next;
      game_over_reg   <= game_over_next;
      invuln_reg      <= invuln_next;
      respawn_reg     <= respawn_next;
    end
  end

`ifdef LIFE_CTRL_BLINK_EN
  localparam int BLINK_W = BLINK_LOG2 + 1;

  logic [BLINK_W-1:0] blink_reg, blink_next;
  logic               visible_reg, visible_next;

  // Counter restarts at 0 on each HIT entry so every window starts visible.
  always_comb begin
    blink_next = '0;
    if (state_reg == HIT && state_next == HIT) begin
      blink_next = blink_reg + BLINK_W'(1);
    end
    visible_next = (state_next == HIT) ? ~blink_next[BLINK_LOG2] : 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_reg   <= '0;
      visible_reg <= 1'b1;
    end else begin
      blink_reg   <= blink_next;
      visible_reg <= visible_next;
    end
  end

  assign bomberman_visible = visible_reg;
`else
  assign bomberman_visible = 1'b1;
`endif

  assign enemy_start   = enemy_start_reg;
  assign game_over     = game_over_reg;
  assign lives         = lives_reg;
  assign invuln        = invuln_reg;
  assign respawn_pulse = respawn_reg;

endmodule

// File: tb/tb_bomberman_life_ctrl.sv
// Self-checking bench for bomberman_life_ctrl (NUM_ENEMIES=3, START_GAP=4, LIVES=3,
// INVULN_CYCLES=8, BLINK_LOG2=1); honours LIFE_CTRL_BLINK_EN for the sprite checks.
module tb_bomberman_life_ctrl;

  typedef struct packed {
    logic [2:0] es;
    logic       go;
    logic [3:0] lv;
    logic       inv;
    logic       resp;
    logic       vis;
  } out_t;

  typedef struct {
    logic       start;
    logic [2:0] death;
    out_t       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_btn;
  logic [2:0] death_signal;
  logic [2:0] enemy_start;
  logic       game_over;
  logic [3:0] lives;
  logic       invuln;
  logic       respawn_pulse;
  logic       bomberman_visible;

  int   checks = 0;
  int   errors = 0;
  out_t sb[$];
  vec_t vecs[20];

  bomberman_life_ctrl #(
    .NUM_ENEMIES   (3),
    .START_GAP     (4),
    .LIVES         (3),
    .INVULN_CYCLES (8),
    .BLINK_LOG2    (1)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start_btn         (start_btn),
    .death_signal      (death_signal),
    .enemy_start       (enemy_start),
    .game_over         (game_over),
    .lives             (lives),
    .invuln            (invuln),
    .respawn_pulse     (respawn_pulse),
    .bomberman_visible (bomberman_visible)
  );

  always #5 clk = ~clk;

  // Blink-phase expectation applies only when the blink feature is built in.
  function automatic logic vis_exp(input logic blink_val);
`ifdef LIFE_CTRL_BLINK_EN
    return blink_val;
`else
    return 1'b1;
`endif
  endfunction

  function automatic out_t mk(input logic [2:0] es, input logic go, input logic [3:0] lv,
                              input logic inv, input logic resp, input logic vis);
    out_t o;
    o.es = es; o.go = go; o.lv = lv; o.inv = inv; o.resp = resp; o.vis = vis_exp(vis);
    return o;
  endfunction

  function automatic vec_t mv(input logic s, input logic [2:0] d, input out_t e);
    vec_t v;
    v.start = s; v.death = d; v.exp = e;
    return v;
  endfunction

  task automatic compare(input string name);
    out_t act, exp;
    act = '{enemy_start, game_over, lives, invuln, respawn_pulse, bomberman_visible};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: no expected entry, got %b", name, act);
    end else begin
      exp = sb.pop_front();
      if (act !== exp) begin
        errors++;
        $display("FAIL %s: got es=%b go=%b lives=%0d inv=%b resp=%b vis=%b, exp es=%b go=%b lives=%0d inv=%b resp=%b vis=%b",
                 name, act.es, act.go, act.lv, act.inv, act.resp, act.vis,
                 exp.es, exp.go, exp.lv, exp.inv, exp.resp, exp.vis);
      end else begin
        $display("ok   %s: es=%b go=%b lives=%0d inv=%b resp=%b vis=%b",
                 name, act.es, act.go, act.lv, act.inv, act.resp, act.vis);
      end
    end
  endtask

  task automatic step(input logic s, input logic [2:0] d, input out_t e, input string name);
    @(negedge clk);
    start_btn    = s;
    death_signal = d;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare(name);
  endtask

  task automatic async_reset_check(input string name);
    @(negedge clk);
    #2;
    reset = 1'b1;
    sb.push_back(mk(3'b000, 1'b0, 4'd3, 1'b1, 1'b0, 1'b1));
    #1;
    compare(name);
    @(negedge clk);
    reset        = 1'b0;
    start_btn    = 1'b0;
    death_signal = 3'b000;
  endtask

  // Start from IDLE and run the full three-enemy release into PLAY.
  task automatic start_game();
    for (int k = 1; k <= 9; k++) begin
      logic [2:0] es;
      es = (k < 5) ? 3'b001 : ((k < 9) ? 3'b011 : 3'b111);
      step((k == 1), 3'b000, mk(es, 1'b0, 4'd3, (k < 9), 1'b0, 1'b1), $sformatf("release c%0d", k));
    end
  endtask

  initial begin
    reset        = 1'b1;
    start_btn    = 1'b0;
    death_signal = 3'b000;

    vecs[0]  = mv(1, 3'b000, mk(3'b001, 0, 3, 1, 0, 1));
    vecs[1]  = mv(0, 3'b111, mk(3'b001, 0, 3, 1, 0, 1));
    vecs[2]  = mv(0, 3'b000, mk(3'b001, 0, 3, 1, 0, 1));
    vecs[3]  = mv(0, 3'b101, mk(3'b001, 0, 3, 1, 0, 1));
    vecs[4]  = mv(0, 3'b000, mk(3'b011, 0, 3, 1, 0, 1));
    vecs[5]  = mv(0, 3'b010, mk(3'b011, 0, 3, 1, 0, 1));
    vecs[6]  = mv(0, 3'b000, mk(3'b011, 0, 3, 1, 0, 1));
    vecs[7]  = mv(1, 3'b000, mk(3'b011, 0, 3, 1, 0, 1));
    vecs[8]  = mv(0, 3'b111, mk(3'b111, 0, 3, 0, 0, 1));
    vecs[9]  = mv(0, 3'b000, mk(3'b111, 0, 3, 0, 0, 1));
    vecs[10] = mv(0, 3'b010, mk(3'b111, 0, 2, 1, 1, 1));
    vecs[11] = mv(0, 3'b000, mk(3'b111, 0, 2, 1, 0, 1));
    vecs[12] = mv(0, 3'b111, mk(3'b111, 0, 2, 1, 0, 0));
    vecs[13] = mv(0, 3'b111, mk(3'b111, 0, 2, 1, 0, 0));
    vecs[14] = mv(0, 3'b000, mk(3'b111, 0, 2, 1, 0, 1));
    vecs[15] = mv(0, 3'b000, mk(3'b111, 0, 2, 1, 0, 1));
    vecs[16] = mv(0, 3'b000, mk(3'b111, 0, 2, 1, 0, 0));
    vecs[17] = mv(0, 3'b000, mk(3'b111, 0, 2, 1, 0, 0));
    vecs[18] = mv(0, 3'b000, mk(3'b111, 0, 2, 0, 0, 1));
    vecs[19] = mv(0, 3'b000, mk(3'b111, 0, 2, 0, 0, 1));

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    sb.push_back(mk(3'b000, 0, 3, 1, 0, 1));
    compare("reset values");
    reset = 1'b0;

    // Release sequence, STAGGER ignoring hits, single hit and HIT window
    for (int i = 0; i < 20; i++) begin
      step(vecs[i].start, vecs[i].death, vecs[i].exp, $sformatf("vec %0d", i));
    end

    // Level semantics with merged simultaneous hits, ending in OVER
    async_reset_check("reset from PLAY");
    start_game();
    for (int k = 0; k < 20; k++) begin
      logic [3:0] lv;
      logic       inv, resp, go, vis;
      int         p;
      lv   = (k < 9) ? 4'd2 : ((k < 18) ? 4'd1 : 4'd0);
      go   = (k >= 18);
      resp = (k == 0) || (k == 9);
      inv  = (k < 8) || (k >= 9 && k < 17);
      p    = (k < 8) ? k : k - 9;
      vis  = inv ? ~(p[1]) : 1'b1;
      step(1'b0, 3'b101, mk(3'b111, go, lv, inv, resp, vis), $sformatf("hold 101 k%0d", k));
    end

    // OVER is terminal
    for (int k = 0; k < 50; k++) begin
      step(k[0], 3'($urandom_range(0, 7)), mk(3'b111, 1, 0, 0, 0, 1), $sformatf("over k%0d", k));
    end
    async_reset_check("reset from OVER");

    // Reset mid-HIT window
    start_game();
    step(1'b0, 3'b100, mk(3'b111, 0, 2, 1, 1, 1), "midhit entry");
    for (int k = 1; k < 4; k++) begin
      step(1'b0, 3'b000, mk(3'b111, 0, 2, 1, 0, ~(k >= 2)), $sformatf("midhit k%0d", k));
    end
    async_reset_check("reset mid-HIT");
    step(1'b0, 3'b111, mk(3'b000, 0, 3, 1, 0, 1), "idle after reset");
    step(1'b1, 3'b000, mk(3'b001, 0, 3, 1, 0, 1), "restart after reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
